// File: rtl/mat_mult_host_if.sv
// mat_mult_host_if: streaming host front end for the complex matrix-multiply engine.
// Packs 4*N*N operand words into mm_a/mm_b, runs the valid->start kick, waits for done
// with a timeout, captures mm_out and streams 2*N*N result words back out.
module mat_mult_host_if #(
    parameter int N       = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [63:0]          in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [63:0]          out_data,
    output logic                 out_last,
    output logic [128*N*N-1:0]   mm_a,
    output logic [128*N*N-1:0]   mm_b,
    output logic                 mm_valid,
    output logic                 mm_start,
    input  logic [128*N*N-1:0]   mm_out,
    input  logic                 mm_done,
    output logic                 busy,
    output logic                 err
);

    localparam int unsigned MAT_WORDS   = 2 * N * N;
    localparam int unsigned FRAME_WORDS = 2 * MAT_WORDS;
    localparam int unsigned IN_CW       = $clog2(FRAME_WORDS);
    localparam int unsigned OUT_CW      = $clog2(MAT_WORDS);
    localparam int unsigned WAIT_CW     = $clog2(TIMEOUT);

    localparam logic [IN_CW-1:0]   IN_LAST   = IN_CW'(FRAME_WORDS - 1);
    localparam logic [OUT_CW-1:0]  OUT_LAST  = OUT_CW'(MAT_WORDS - 1);
    localparam logic [WAIT_CW-1:0] WAIT_LAST = WAIT_CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_KV,
        ST_KVS,
        ST_KS,
        ST_WAIT,
        ST_DRAIN
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [IN_CW-1:0]     in_cnt;
    logic [OUT_CW-1:0]    out_cnt;
    logic [WAIT_CW-1:0]   wait_cnt;
    logic [128*N*N-1:0]   res;
    logic                 in_fire;
    logic                 out_fire;
    logic                 wait_last;

    // in_ready is only ever high in LOAD, so it alone qualifies an input transfer
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign wait_last = (wait_cnt == WAIT_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: load, three-cycle kick, wait for done or timeout, drain
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_LOAD:  if (in_fire && in_cnt == IN_LAST) state_nxt = ST_KV;
            ST_KV:    state_nxt = ST_KVS;
            ST_KVS:   state_nxt = ST_KS;
            ST_KS:    state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (mm_done) begin
                    state_nxt = ST_DRAIN;
                end else if (wait_last) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_DRAIN: if (out_fire && out_cnt == OUT_LAST) state_nxt = ST_LOAD;
            default:  state_nxt = ST_LOAD;
        endcase
    end

    // State-decoded outputs; reset forces LOAD so these drop asynchronously
    always_comb begin
        mm_valid  = 1'b0;
        mm_start  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state)
            ST_LOAD:  busy = 1'b0;
            ST_KV:    mm_valid = 1'b1;
            ST_KVS: begin
                mm_valid = 1'b1;
                mm_start = 1'b1;
            end
            ST_KS:    mm_start = 1'b1;
            ST_WAIT:  ;
            ST_DRAIN: out_valid = 1'b1;
            default:  busy = 1'b1;
        endcase
    end

    // Registered in_ready: opens the edge after reset and the edge that returns to LOAD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready <= 1'b0;
        end else begin
            in_ready <= (state_nxt == ST_LOAD);
        end
    end

    // Operand registers: word k of the frame lands in mm_a or mm_b at a fixed 64-bit slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mm_a <= '0;
            mm_b <= '0;
        end else if (in_fire) begin
            for (int unsigned w = 0; w < MAT_WORDS; w++) begin
                if (in_cnt == IN_CW'(w)) begin
                    mm_a[64*w +: 64] <= in_data;
                end
                if (in_cnt == IN_CW'(w + MAT_WORDS)) begin
                    mm_b[64*w +: 64] <= in_data;
                end
            end
        end
    end

    // Input word counter; wraps on the last word so LOAD always re-enters at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt <= '0;
        end else if (in_fire) begin
            in_cnt <= (in_cnt == IN_LAST) ? '0 : in_cnt + IN_CW'(1);
        end
    end

    // WAIT cycle counter, cleared whenever WAIT is not continuing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == ST_WAIT && state_nxt == ST_WAIT) begin
            wait_cnt <= wait_cnt + WAIT_CW'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // Result capture on done; a done pulse outside WAIT is ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res <= '0;
        end else if (state == ST_WAIT && mm_done) begin
            res <= mm_out;
        end
    end

    // Output word index, advanced per accepted result word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt <= '0;
        end else if (out_fire) begin
            out_cnt <= (out_cnt == OUT_LAST) ? '0 : out_cnt + OUT_CW'(1);
        end
    end

    // Sticky timeout flag, cleared by the first accepted word of the next frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (state == ST_WAIT && !mm_done && wait_last) begin
            err <= 1'b1;
        end else if (in_fire && in_cnt == '0) begin
            err <= 1'b0;
        end
    end

    // Result word select; held stable while out_ready is low since out_cnt does not move
    always_comb begin
        out_data = '0;
        for (int unsigned w = 0; w < MAT_WORDS; w++) begin
            if (out_valid && out_cnt == OUT_CW'(w)) begin
                out_data = res[64*w +: 64];
            end
        end
        out_last = out_valid && (out_cnt == OUT_LAST);
    end

endmodule

// File: doc/mat_mult_host_if.md
# mat_mult_host_if

Streaming host-side front end for the complex matrix-multiply engine (`mat_mult_complex`). It collects operand words from a ready/valid input stream and packs them into the flat `mat_a`/`mat_b` buses. It then drives the engine's valid→start kick sequence, waits for `done` with a timeout, captures the result, and streams the result words back out. The block sits between the system data path and the engine, so no other logic has to know the engine's handshake.

## Interface
- `N`, 3: matrix dimension. Matrices are N×N and must match the engine's `mat_num_row`.
- `TIMEOUT`, 1024: maximum WAIT cycles before the block aborts.
- `clk`  in  1: clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: input word valid.
- `in_ready`  out  1: block accepts an input word.
- `in_data`  in  64: operand word.
- `out_valid`  out  1: result word valid.
- `out_ready`  in  1: downstream accepts a result word.
- `out_data`  out  64: result word.
- `out_last`  out  1: marks the final result word, index 2N²−1.
- `mm_a`  out  128N²: drives the engine's `mat_a`.
- `mm_b`  out  128N²: drives the engine's `mat_b`.
- `mm_valid`  out  1: engine `valid`.
- `mm_start`  out  1: engine `start`.
- `mm_out`  in  128N²: engine `mat_out`.
- `mm_done`  in  1: engine `done`. This is a one-cycle pulse.
- `busy`  out  1: high in every state except LOAD.
- `err`  out  1: sticky timeout flag.

## Operation
- **Frame order.** Each frame is 4N² input words, numbered k = 0..4N²−1:
  - k < 2N²: word k goes to `mm_a[64k +: 64]`. Words 0..N²−1 are real parts and words N²..2N²−1 are imaginary parts, both row-major.
  - k ≥ 2N²: word k goes to `mm_b[64(k−2N²) +: 64]`, with the same layout.
- **Transfers.** A word transfers when `in_valid && in_ready`.
- **Operand stability.** `mm_a` and `mm_b` are registers. They hold their value from the last load until the next frame's first accepted word.
- **States.**
  - LOAD: `in_ready`=1. Counts accepted words. The transfer of word 4N²−1 moves the block to KV.
  - KV: `mm_valid`=1, `mm_start`=0. Moves to KVS after 1 cycle.
  - KVS: `mm_valid`=1, `mm_start`=1. Moves to KS after 1 cycle.
  - KS: `mm_valid`=0, `mm_start`=1. Moves to WAIT after 1 cycle.
  - WAIT: all kick outputs are 0 and the WAIT counter increments.
    - `mm_done`=1: `mm_out` is captured into a result register and the block moves to DRAIN.
    - Otherwise, when the counter reaches TIMEOUT−1: `err` is set and the block returns to LOAD without draining.
  - DRAIN: `out_valid`=1 and `out_data` = result word j, which is `res[64j +: 64]`.
    - j advances on each `out_valid && out_ready`.
    - `out_last`=1 when j = 2N²−1.
    - The transfer of the last word returns the block to LOAD and resets j and the input count to 0.
- **Error flag.** `err` clears when the first word of the next frame is accepted.
- **Mid-frame stalls.** `in_valid` may drop at any point in LOAD. The block keeps its partial count; there is no timeout in LOAD.
- **Input closed outside LOAD.** `in_ready`=0 in all other states, so input words offered during KV..DRAIN are not consumed.
- **Unexpected done.** An `mm_done` seen outside WAIT is ignored.
- **Pass-through data.** `out_data` is the captured value and is not modified. Result words 0..N²−1 are real parts and N²..2N²−1 are imaginary parts, row-major.

## Timing
- **Reset.** While `rst_n`=0, every output is 0 and all registers are cleared:
  - state is LOAD, all counters are 0, `mm_a` = `mm_b` = 0, the result register is 0.
  - `in_ready` is registered. It rises on the first clock edge after `rst_n` deasserts.
- **Kick sequence.** Let edge L be the edge that accepts the last input word.
  - `mm_valid` is high in cycles L+1 and L+2.
  - `mm_start` is high in cycles L+2 and L+3.
  - WAIT begins at cycle L+4.
- **Capture latency.** If `mm_done` is sampled at edge D, `out_valid` is high from cycle D+1.
- **Output throughput.** One result word per cycle when `out_ready` is held high. Minimum drain time is 2N² cycles.
- **Frame turnaround.** `in_ready` rises in the cycle after the last output transfer.
- **Throughput bound.** Minimum frame period is 4N² + 4 + engine latency + 2N² cycles.
- **Output stalls.** If `out_ready` is low, `out_data` and `out_last` hold their values.
- **Asynchronous reset mid-operation.** Asserting `rst_n`=0 in any state aborts immediately:
  - `mm_valid`, `mm_start` and `out_valid` drop asynchronously.
  - No partial output is produced.

## Test plan
- Identity × M, N=3, TIMEOUT=1024. Stream A=I (real part I, imaginary part 0) and B with real b_k=k, imaginary b_k=100+k, all 36 words back-to-back. Use a behavioural engine model with latency 10.
  -> `mm_valid`/`mm_start` pulses at exactly L+1..L+3.
  -> Output is 18 words: 0..8, then 100..108. `out_last` is high only on the 18th word.
- Complex product. A all (1+1i), B all (2+0i).
  -> Every output element is real 6, imaginary 6.
- Input gaps and output backpressure. `in_valid` toggles 1/0 while loading; `out_ready` is low on alternate cycles while draining.
  -> Same results as the uninterrupted run.
  -> `out_data` is stable while `out_ready` is low.
  -> No word is duplicated or dropped.
- Timeout. The engine model never asserts `mm_done`.
  -> `err`=1 at WAIT cycle 1024, the block returns to LOAD, and `out_valid` stays 0.
  -> The next frame's first accepted word clears `err`.
- Reset mid-DRAIN. Pull `rst_n` low after 5 output words.
  -> All outputs are 0 immediately.
  -> After release, `in_ready`=1 at the next edge and a fresh frame completes correctly.
- Spurious `mm_done` pulsed during LOAD, and `in_valid` held high during WAIT.
  -> No state change, no extra input words consumed, and the result matches the expected product.
